// File: rtl/tcam_query_ctrl.sv
// tcam_query_ctrl
//   Command front end for tcam_top. Accepts SEARCH / WRITE commands, drives the
//   registered tcam_top request fields, and recovers search responses by fixed
//   latency. tcam_top flags data_vld only on a hit, so a tag pipe tells us when a
//   response (hit or miss) is due. Results go through a small FIFO with
//   valid/ready backpressure. Writes share the value SRAM address port with
//   search readout, so a WRITE waits until every in-flight search is captured.
//
//   Ports
//     clk, rst_n                      clock, synchronous active-low reset
//     cmd_valid/ready/op/key/addr/data/tag   command stream (op 0=SEARCH, 1=WRITE)
//     req_search/key, req_we/addr/data       registered tcam_top request fields
//     resp_data_vld/addr/data                tcam_top response (data_vld = hit)
//     res_valid/ready/hit/addr/data/tag      result stream, issue order
//     busy                                   searches in flight, results queued, or not RUN
module tcam_query_ctrl #(
    parameter  int KEY_WIDTH   = 32,
    parameter  int VALUE_WIDTH = 32,
    parameter  int VALUE_DEPTH = 16,
    parameter  int TAG_WIDTH   = 4,
    parameter  int RESP_LAT    = 2,
    parameter  int RESP_DEPTH  = 4,
    localparam int AW          = $clog2(VALUE_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [VALUE_WIDTH-1:0] cmd_data,
    input  logic [TAG_WIDTH-1:0]   cmd_tag,
    output logic                   req_search,
    output logic [KEY_WIDTH-1:0]   req_key,
    output logic                   req_we,
    output logic [AW-1:0]          req_addr,
    output logic [VALUE_WIDTH-1:0] req_data,
    input  logic                   resp_data_vld,
    input  logic [AW-1:0]          resp_addr,
    input  logic [VALUE_WIDTH-1:0] resp_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_hit,
    output logic [AW-1:0]          res_addr,
    output logic [VALUE_WIDTH-1:0] res_data,
    output logic [TAG_WIDTH-1:0]   res_tag,
    output logic                   busy
);
    localparam int IW = $clog2(RESP_LAT + 2);   // inflight spans 0..RESP_LAT+1
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_WRITE} state_t;

    typedef struct packed {
        logic                   hit;
        logic [AW-1:0]          addr;
        logic [VALUE_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]   tag;
    } res_t;

    state_t                         state_q, state_d;
    logic                           req_search_q, req_we_q;
    logic [KEY_WIDTH-1:0]           req_key_q;
    logic [AW-1:0]                  req_addr_q;
    logic [VALUE_WIDTH-1:0]         req_data_q;
    logic [TAG_WIDTH-1:0]           req_tag_q;
    logic [RESP_LAT-1:0]            pv_q;
    logic [RESP_LAT-1:0][TAG_WIDTH-1:0] pt_q;
    logic [IW-1:0]                  inflight_q, inflight_d;
    res_t                           fifo_q [RESP_DEPTH];
    logic [PW-1:0]                  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                  cnt_q, cnt_d;

    logic ready_raw, credit_ok, search_acc, write_acc, push, pop;
    res_t ent_in;

    // Credit counts registered state only: a pop this cycle frees a slot next cycle.
    assign credit_ok  = (32'(cnt_q) + 32'(inflight_q)) < 32'(RESP_DEPTH);
    assign cmd_ready  = ready_raw & rst_n;
    assign search_acc = cmd_valid & cmd_ready & ~cmd_op;
    assign write_acc  = cmd_valid & cmd_ready & cmd_op;

    always_comb begin
        state_d   = state_q;
        ready_raw = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (!cmd_op) begin
                    ready_raw = credit_ok;
                end else begin
                    ready_raw = (inflight_q == '0);
                    if (cmd_valid) state_d = (inflight_q == '0) ? S_WRITE : S_DRAIN;
                end
            end
            // Back to RUN first; the held WRITE is then accepted from RUN.
            S_DRAIN: if (inflight_q == '0) state_d = S_RUN;
            S_WRITE: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Last tag-pipe stage is the cycle the response for that search is on resp_*.
    assign push       = pv_q[RESP_LAT-1];
    assign pop        = res_valid & res_ready;
    assign ent_in.hit  = resp_data_vld;
    assign ent_in.addr = resp_data_vld ? resp_addr : '0;
    assign ent_in.data = resp_data_vld ? resp_data : '0;
    assign ent_in.tag  = pt_q[RESP_LAT-1];

    assign inflight_d = inflight_q + IW'(search_acc) - IW'(push);
    assign cnt_d      = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            req_search_q <= 1'b0;
            req_we_q     <= 1'b0;
            req_key_q    <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_tag_q    <= '0;
            pv_q         <= '0;
            pt_q         <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            req_search_q <= search_acc;
            req_we_q     <= write_acc;
            if (search_acc) begin
                req_key_q <= cmd_key;
                req_tag_q <= cmd_tag;
            end
            if (write_acc) begin
                req_addr_q <= cmd_addr;
                req_data_q <= cmd_data;
            end
            pv_q[0] <= req_search_q;
            pt_q[0] <= req_tag_q;
            for (int i = 1; i < RESP_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
            inflight_q <= inflight_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= ent_in;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Credit makes overflow impossible; a push into a full FIFO without a pop is a bug.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == CW'(RESP_DEPTH)));

    assign req_search = req_search_q;
    assign req_key    = req_key_q;
    assign req_we     = req_we_q;
    assign req_addr   = req_addr_q;
    assign req_data   = req_data_q;

    assign res_valid  = (cnt_q != '0);
    assign res_hit    = fifo_q[rd_ptr_q].hit;
    assign res_addr   = fifo_q[rd_ptr_q].addr;
    assign res_data   = fifo_q[rd_ptr_q].data;
    assign res_tag    = fifo_q[rd_ptr_q].tag;

    assign busy = (inflight_q != '0) || (cnt_q != '0) || (state_q != S_RUN);

endmodule

// File: tb/tb_tcam_query_ctrl.sv
// Bench for tcam_query_ctrl: a fixed-latency tcam_top model (entry = key when
// key < 16, value SRAM written by req_we) plus a transaction-level scoreboard
// of outstanding searches, checked every cycle, and directed literal checks.
module tb_tcam_query_ctrl;
    localparam int KW = 32, VW = 32, VD = 16, TW = 4, RL = 2, RD = 4, AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [KW-1:0] cmd_key = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [VW-1:0] cmd_data = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          cmd_ready, req_search, req_we, res_valid, res_hit, busy;
    logic [KW-1:0] req_key;
    logic [AW-1:0] req_addr, res_addr;
    logic [VW-1:0] req_data, res_data;
    logic [TW-1:0] res_tag;
    logic          resp_data_vld = 1'b0;
    logic [AW-1:0] resp_addr = '0;
    logic [VW-1:0] resp_data = '0;
    logic          rr_fixed = 1'b1, rr_rand = 1'b1, rand_rdy = 1'b0, res_ready;
    assign res_ready = rand_rdy ? rr_rand : rr_fixed;

    tcam_query_ctrl #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .VALUE_DEPTH(VD), .TAG_WIDTH(TW),
                      .RESP_LAT(RL), .RESP_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
        .req_search(req_search), .req_key(req_key), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .resp_data_vld(resp_data_vld), .resp_addr(resp_addr), .resp_data(resp_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
        .res_addr(res_addr), .res_data(res_data), .res_tag(res_tag), .busy(busy));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic          hit;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          exp_q[$];        // accepted searches not yet consumed, issue order
    bit   [2:0]    acc_hist = '0;   // bit k: search accepted k edges before the last one
    bit            wrote_last = 0, drain = 0, started = 0, force_miss = 0;
    logic [KW-1:0] last_key = '0;
    logic [AW-1:0] last_addr = '0;
    logic [VW-1:0] last_data = '0;
    logic [VW-1:0] ref_mem[VD], tc_mem[VD];
    bit            h0v = 0, h1v = 0;
    logic [KW-1:0] h0k = '0, h1k = '0;
    int            we_cnt = 0;
    logic [TW-1:0] tag_log[$];

    function automatic int infl();
        return int'(acc_hist[0]) + int'(acc_hist[1]) + int'(acc_hist[2]);
    endfunction

    function automatic bit exp_ready();
        if (rst_n !== 1'b1 || wrote_last || drain) return 1'b0;
        if (!cmd_op) return exp_q.size() < RD;
        return infl() == 0;
    endfunction

    always begin
        int   nf;
        bit   acc, dn;
        exp_t e;
        @(negedge clk); #1;
        // tcam_top model: response RL cycles after the req_search cycle
        if (started && req_we === 1'b1) begin
            chk("we_during_pending_read", {63'd0, h0v | h1v | (req_search === 1'b1)}, 64'd0);
            tc_mem[req_addr] = req_data;
            we_cnt++;
        end
        if (h1v && !force_miss && h1k[KW-1:4] == '0) begin
            resp_data_vld = 1'b1;
            resp_addr     = h1k[AW-1:0];
            resp_data     = tc_mem[h1k[AW-1:0]];
        end else begin
            resp_data_vld = 1'b0;
            resp_addr     = AW'($urandom);
            resp_data     = $urandom;
        end
        h1v = h0v; h1k = h0k;
        h0v = started && (req_search === 1'b1); h0k = req_key;

        nf = exp_q.size() - infl();
        if (started) begin
            chk("req_search", {63'd0, req_search}, {63'd0, acc_hist[0]});
            chk("req_we", {63'd0, req_we}, {63'd0, wrote_last});
            chk("req_key", 64'(req_key), 64'(last_key));
            chk("req_addr", 64'(req_addr), 64'(last_addr));
            chk("req_data", 64'(req_data), 64'(last_data));
            chk("res_valid", {63'd0, res_valid}, {63'd0, nf > 0});
            if (nf > 0) begin
                chk("res_hit", {63'd0, res_hit}, {63'd0, exp_q[0].hit});
                chk("res_addr", 64'(res_addr), 64'(exp_q[0].addr));
                chk("res_data", 64'(res_data), 64'(exp_q[0].data));
                chk("res_tag", 64'(res_tag), 64'(exp_q[0].tag));
            end
            chk("busy", {63'd0, busy}, {63'd0, exp_q.size() > 0 || drain || wrote_last});
            if (cmd_valid) chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, exp_ready()});
            if (res_valid === 1'b1 && res_ready) tag_log.push_back(res_tag);
        end

        if (rst_n !== 1'b1) begin
            exp_q.delete();
            acc_hist = '0; wrote_last = 0; drain = 0;
            last_key = '0; last_addr = '0; last_data = '0;
            h0v = 0; h1v = 0;
            started = 1;
        end else if (started) begin
            acc = cmd_valid && exp_ready();
            if (nf > 0 && res_ready) void'(exp_q.pop_front());
            dn = drain ? (infl() != 0) : (!wrote_last && cmd_valid && cmd_op && infl() != 0);
            if (acc && !cmd_op) begin
                e.hit  = !force_miss && cmd_key[KW-1:4] == '0;
                e.addr = e.hit ? cmd_key[AW-1:0] : '0;
                e.data = e.hit ? ref_mem[cmd_key[AW-1:0]] : '0;
                e.tag  = cmd_tag;
                exp_q.push_back(e);
                last_key = cmd_key;
            end
            if (acc && cmd_op) begin
                ref_mem[cmd_addr] = cmd_data;
                last_addr = cmd_addr;
                last_data = cmd_data;
            end
            acc_hist   = {acc_hist[1:0], acc && !cmd_op};
            wrote_last = acc && cmd_op;
            drain      = dn;
        end
    end

    always @(negedge clk) rr_rand = ($urandom_range(0, 3) != 0);

    // ---------------- driver ----------------
    task automatic send(input logic op, input logic [KW-1:0] key, input logic [AW-1:0] addr,
                        input logic [VW-1:0] data, input logic [TW-1:0] tag, output int n);
        logic a;
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_addr = addr;
        cmd_data = data; cmd_tag = tag;
        n = 0;
        do begin
            #1 a = cmd_ready;
            @(negedge clk);
            n++;
        end while (a !== 1'b1 && n < 200);
        cmd_valid = 1'b0;
        if (a !== 1'b1) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_res(output int n);
        n = 0;
        #2;
        while (res_valid !== 1'b1 && n < 50) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= 50) chk("res_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        #2;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk); #2;
            n++;
        end
        chk("idle_timeout", {63'd0, n >= 300}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, expected finish well before 60000 cycles");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, acc, nt, tl0, seen;
        logic [AW-1:0] ra;
        logic [VW-1:0] rd;
        logic [KW-1:0] rk;
        logic [TW-1:0] rt;
        logic ro;
        for (int i = 0; i < VD; i++) begin
            ref_mem[i] = 32'h5A00_0000 | i;
            tc_mem[i]  = 32'h5A00_0000 | i;
        end

        // 1. reset with a pending command
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_req", {62'd0, req_search, req_we}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);

        // 2. write entry 3, then search it
        w0 = we_cnt;
        send(1'b1, '0, 4'd3, 32'hCAFE_0003, '0, n);
        send(1'b0, 32'd3, '0, '0, 4'd5, n);
        wait_res(n);
        chk("t2_hit", {63'd0, res_hit}, 64'd1);
        chk("t2_addr", 64'(res_addr), 64'd3);
        chk("t2_data", 64'(res_data), 64'hCAFE_0003);
        chk("t2_tag", 64'(res_tag), 64'd5);
        chk("t2_we_pulses", 64'(we_cnt - w0), 64'd1);
        @(negedge clk);
        wait_idle();

        // 3. miss, with latency from acceptance
        force_miss = 1;
        send(1'b0, 32'd3, '0, '0, 4'd2, n);
        wait_res(n);
        chk("t3_latency", 64'(n), 64'(RL + 1));
        chk("t3_hit", {63'd0, res_hit}, 64'd0);
        chk("t3_addr", 64'(res_addr), 64'd0);
        chk("t3_data", 64'(res_data), 64'd0);
        chk("t3_tag", 64'(res_tag), 64'd2);
        @(negedge clk);
        wait_idle();
        force_miss = 0;

        // 4. backpressure: only RD searches fit while results are not taken
        rr_fixed = 1'b0; acc = 0; nt = 0;
        tl0 = tag_log.size();
        for (int c = 0; c < 10; c++) begin
            cmd_valid = 1'b1; cmd_op = 1'b0; cmd_key = KW'(nt); cmd_tag = TW'(nt);
            #1 if (cmd_ready === 1'b1) begin acc++; nt++; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("t4_accepted", 64'(acc), 64'd4);
        rr_fixed = 1'b1;
        for (int t = 4; t < 8; t++) send(1'b0, KW'(t), '0, '0, TW'(t), n);
        wait_idle();
        chk("t4_count", 64'(tag_log.size() - tl0), 64'd8);
        for (int i = 0; i < 8; i++)
            if (tl0 + i < tag_log.size()) chk("t4_order", 64'(tag_log[tl0 + i]), 64'(i));

        // 5. write hazard: WRITE behind two searches waits for both captures
        send(1'b0, 32'd5, '0, '0, 4'd1, n);
        send(1'b0, 32'h100, '0, '0, 4'd2, n);
        send(1'b1, '0, 4'd7, 32'h7777_0007, '0, n);
        chk("t5_write_wait", 64'(n), 64'd5);
        wait_idle();
        send(1'b0, 32'd7, '0, '0, 4'd9, n);
        wait_res(n);
        chk("t5_data", 64'(res_data), 64'h7777_0007);
        chk("t5_tag", 64'(res_tag), 64'd9);
        @(negedge clk);
        wait_idle();

        // 6. reset with two searches in flight
        send(1'b0, 32'd1, '0, '0, 4'd3, n);
        send(1'b0, 32'd2, '0, '0, 4'd4, n);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk); #2;
            if (res_valid !== 1'b0) seen = 1;
        end
        chk("t6_no_result", 64'(seen), 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);

        // random traffic with random result backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 240; i++) begin
            if (i % 60 == 59) begin
                wait_idle();
                force_miss = ~force_miss;
            end
            ro = ($urandom_range(0, 4) == 0);
            rk = ($urandom_range(0, 2) == 0) ? KW'($urandom) : KW'($urandom_range(0, VD - 1));
            ra = AW'($urandom);
            rd = $urandom;
            rt = TW'($urandom);
            send(ro, rk, ra, rd, rt, n);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rand_rdy = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
